// File: rtl/memory_pkg.sv
// memory_pkg: shared card encoding, FSM states and field helpers for the memory game
package memory_pkg;
  localparam int CARD_W = 5;
  localparam int SYM_W = 3;
  localparam int N_CARDS = 16;
  localparam logic [3:0] N_PAIRS = 4'd8;
  typedef enum logic [1:0] {HIDDEN = 2'b00, UP = 2'b01, MATCHED = 2'b10} card_status_t;
  typedef enum logic [2:0] {EMPTY = 3'd0, FIRST = 3'd1, SECOND = 3'd2, COMPARE = 3'd3, SHOW = 3'd4, DONE = 3'd5} match_state_t;
  typedef logic [CARD_W-1:0] card_t;
  function automatic logic [SYM_W-1:0] card_sym(card_t c);
    return c[CARD_W-1:2];
  endfunction
  function automatic card_status_t card_status(card_t c);
    return card_status_t'(c[1:0]);
  endfunction
endpackage

// File: rtl/card_match_ctrl_show_timer.sv
// show_timer: loadable down-counter that holds at zero and flags expiry
module show_timer #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int TW = $clog2(SHOW_CYCLES) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ld_i,
  input  logic          dec_i,
  input  logic [TW-1:0] val_i,
  output logic          expired_o
);
  logic [TW-1:0] cnt_q, cnt_d;
  // clear beats load beats decrement; the count parks at zero
  always_comb cnt_d = clr_i ? '0 : ld_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - TW'(1) : cnt_q;
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/card_match_ctrl.sv
// card_match_ctrl: loads a shuffled deck and runs pair selection, matching and flip-back
module card_match_ctrl
  import memory_pkg::*;
#(
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [N_CARDS-1:0][CARD_W-1:0]  arr_cards_in,
  input  logic                            sel_valid,
  input  logic [3:0]                      sel_idx,
  output logic                            sel_ready,
  output logic [N_CARDS-1:0][CARD_W-1:0]  board,
  output logic                            sel_err,
  output logic                            pair_match,
  output logic                            pair_miss,
  output logic [3:0]                      pairs_found,
  output logic                            game_over,
  output logic [2:0]                      phase
);
  localparam int TW = $clog2(SHOW_CYCLES) + 1;
  match_state_t state_q, state_d;
  card_t [N_CARDS-1:0] board_q, board_d;
  logic [3:0] idx1_q, idx1_d, idx2_q, idx2_d, pairs_q, pairs_d;
  logic err_q, err_d, match_q, match_d, miss_q, miss_d;
  logic sel_ok, sym_eq, expired, unused_low;
  assign unused_low = ^arr_cards_in;
  assign sel_ok = sel_valid && card_status(board_q[sel_idx]) == HIDDEN;
  assign sym_eq = card_sym(board_q[idx1_q]) == card_sym(board_q[idx2_q]);
  show_timer #(.SHOW_CYCLES(SHOW_CYCLES), .TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (load),
    .ld_i     (state_q == COMPARE && !sym_eq),
    .dec_i    (state_q == SHOW),
    .val_i    (TW'(SHOW_CYCLES - 1)),
    .expired_o(expired)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      board_q <= '0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      pairs_q <= '0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      idx1_q  <= idx1_d;
      idx2_q  <= idx2_d;
      pairs_q <= pairs_d;
      err_q   <= err_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end
  // next state: load restarts from any state, otherwise step through the turn
  always_comb begin
    state_d = state_q;
    if (load) state_d = FIRST;
    else case (state_q)
      FIRST:   state_d = sel_ok ? SECOND : FIRST;
      SECOND:  state_d = sel_ok ? COMPARE : SECOND;
      COMPARE: state_d = !sym_eq ? SHOW : (pairs_q + 4'd1 == N_PAIRS) ? DONE : FIRST;
      SHOW:    state_d = expired ? FIRST : SHOW;
      default: state_d = state_q;
    endcase
  end
  // board, pick indices, score and one-cycle event pulses
  always_comb begin
    board_d = board_q;
    idx1_d  = idx1_q;
    idx2_d  = idx2_q;
    pairs_d = pairs_q;
    err_d   = 1'b0;
    match_d = 1'b0;
    miss_d  = 1'b0;
    if (load) begin
      for (int k = 0; k < N_CARDS; k++) board_d[k] = {card_sym(arr_cards_in[k]), HIDDEN};
      pairs_d = '0;
    end else case (state_q)
      FIRST, SECOND: begin
        err_d = sel_valid && !sel_ok;
        if (sel_ok) board_d[sel_idx][1:0] = UP;
        idx1_d = (sel_ok && state_q == FIRST) ? sel_idx : idx1_q;
        idx2_d = (sel_ok && state_q == SECOND) ? sel_idx : idx2_q;
      end
      COMPARE: if (sym_eq) begin
        board_d[idx1_q][1:0] = MATCHED;
        board_d[idx2_q][1:0] = MATCHED;
        match_d = 1'b1;
        pairs_d = pairs_q + 4'd1;
      end
      SHOW: if (expired) begin
        board_d[idx1_q][1:0] = HIDDEN;
        board_d[idx2_q][1:0] = HIDDEN;
        miss_d = 1'b1;
      end
      default: ;
    endcase
  end
  // status outputs decoded from the state register
  always_comb begin
    sel_ready = state_q == FIRST || state_q == SECOND;
    game_over = state_q == DONE;
    phase     = state_q;
  end
  assign board       = board_q;
  assign pairs_found = pairs_q;
  assign sel_err     = err_q;
  assign pair_match  = match_q;
  assign pair_miss   = miss_q;
endmodule

// File: doc/card_match_ctrl.md
Name: card_match_ctrl

Overview:
Game-side consumer of the shuffled deck. It loads the 16-entry card array produced by the shuffler when that block signals done, and accepts player card selections two at a time. It compares the symbols of each pair, marks matches, and flips mismatches back after a display delay. The board is driven to the display and the win logic: each entry is a 5-bit word, symbol in [4:2] and status in [1:0].

Parameters:
N_CARDS, 16, board entries; fixed at 16 (N_PAIRS = 8).
SHOW_CYCLES, 50000000, cycles a mismatched pair stays face-up (1 s at 50 MHz); must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset; one clock, all state on rising edge of clk
load  in  1  one-cycle pulse; latch arr_cards_in and start a new game
arr_cards_in  in  5x16  shuffled deck, [4:2] symbol, [1:0] ignored
sel_valid  in  1  player selection strobe, one cycle
sel_idx  in  4  index of selected card
sel_ready  out  1  high in FIRST and SECOND only
board  out  5x16  current board, [4:2] symbol, [1:0] status
sel_err  out  1  one-cycle pulse: selection rejected
pair_match  out  1  one-cycle pulse: pair matched
pair_miss  out  1  one-cycle pulse: pair flipped back
pairs_found  out  4  matched pairs, 0..8
game_over  out  1  high while in DONE
phase  out  3  current FSM state encoding, for display

Behaviour:
- Status codes: HIDDEN=00, UP=01, MATCHED=10; 11 never produced.
- Reset (sync): every board entry = 0, pairs_found = 0, all pulses 0, game_over = 0, sel_ready = 0, FSM = EMPTY, idx1/idx2 = 0, timer = 0.
- load, any state except reset: board[k] <= {arr_cards_in[k][4:2], 2'b00}; pairs_found <= 0; timer cleared; FSM -> FIRST.
- load has priority over sel_valid and over a timer expiry in the same cycle. rst has priority over load.
- EMPTY: selections ignored, no sel_err.
- FIRST:
  - sel_valid with board[sel_idx] HIDDEN: status <= UP, idx1 <= sel_idx, FSM -> SECOND.
  - sel_valid with the entry not HIDDEN: sel_err pulse, state unchanged.
- SECOND: same acceptance rule (idx1 is UP, so re-selecting it gives sel_err); idx2 <= sel_idx, FSM -> COMPARE.
- COMPARE (exactly 1 cycle, selections ignored):
  - Symbols equal: both statuses <= MATCHED, pair_match = 1 for one cycle, pairs_found + 1. FSM -> DONE if the new count is 8, else FIRST.
  - Symbols differ: timer <= SHOW_CYCLES-1, FSM -> SHOW.
- SHOW: timer decrements each cycle; selections ignored. On the cycle timer == 0, both statuses <= HIDDEN, pair_miss pulse, FSM -> FIRST.
- DONE: game_over = 1; selections ignored; only load or rst leave.
- Latency:
  - Accepted select at edge T: UP visible on board from T.
  - COMPARE occupies cycle T..T+1. Match result visible at T+1.
  - Mismatch flip-back at edge T+1+SHOW_CYCLES.
- Arithmetic: symbol compare on [4:2] only; pairs_found saturates at 8 (cannot exceed by construction). Timer width = $clog2(SHOW_CYCLES)+1.
- Outputs are registered; sel_ready and game_over decode the state register.

Decomposition:
- Shared package memory_pkg holds:
  - card_status_t enum (HIDDEN, UP, MATCHED)
  - match_state_t enum (EMPTY, FIRST, SECOND, COMPARE, SHOW, DONE)
  - constants CARD_W=5, SYM_W=3, N_CARDS=16, N_PAIRS=8
  - functions card_sym() and card_status()
- One sub-module, show_timer: loadable down-counter with load/value inputs and an expired output, parameterised by SHOW_CYCLES.

Test Plan:
- Setup for all scenarios: SHOW_CYCLES=4; deck arr_cards_in[k] = {k>>1, 2'b00}, so cards 2i and 2i+1 share symbol i.
- Reset then load -> board[k] == {k>>1, 00} for all k, phase FIRST, sel_ready = 1, pairs_found = 0.
- Select 4 then 5 -> board[4], board[5] status 10 one cycle after COMPARE, pair_match high exactly 1 cycle, pairs_found = 1.
- Select 0 then 2 -> both UP; 4 cycles later both status 00, pair_miss pulse. Selections during SHOW have no effect and no sel_err.
- Select 3 then 3 again -> sel_err pulse, still in SECOND. Selecting an already MATCHED card in FIRST -> sel_err.
- Match all 8 pairs (2i, 2i+1) -> pairs_found = 8, game_over = 1. A further sel_valid is ignored. Then load -> game_over = 0, all statuses 00.
- Assert rst in the middle of SHOW, and load together with sel_valid -> reset clears to EMPTY with a zero board; load wins and no card turns UP.
